tick_scheduler: RTL and testbench



---
 rtl/tick_scheduler_if.sv | 25 ++
 rtl/tick_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_tick_scheduler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if -- Avalon-MM slave bus bundle for tick_scheduler.
//
// Signals:
//   address    [3:0]  word address               (master -> slave)
//   chipselect        chip select                (master -> slave)
//   write_n           write strobe, active low   (master -> slave)
//   writedata  [15:0] write data                 (master -> slave)
//   readdata   [15:0] registered read data       (slave  -> master)
interface tick_scheduler_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler -- multi-channel software-timer scheduler.
//
// Each system tick walks the NUM_CH down-count channels one per cycle through
// a single shared decrementer. A channel whose count reaches 1 fires: it sets
// its pending bit, pulses ch_fire for one cycle and reloads from PERIOD. One-shot
// channels disable themselves on firing. irq is the OR of pending & mask.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   tick_in    single-cycle tick pulse
//   bus        Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   irq        |(pending & irq_mask)
//   ch_fire    one-cycle pulse per channel expiry
//
// Register map: 0 STATUS {overrun[15], pending} W1C, 1 ENABLE, 2 IRQ_MASK,
// 3 MODE (1=periodic), 4+n PERIOD[n] (write also loads count), 8+n COUNT[n] RO.
//
// Optional: define TICK_SCHED_TICK_COUNT_EN to add a 16-bit accepted-tick
// counter at address 12 (any write clears it).
module tick_scheduler #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_in,
    tick_scheduler_if.slave   bus,
    output logic              irq,
    output logic [NUM_CH-1:0] ch_fire
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tick_pend_q, tick_pend_d;
    logic              overrun_q, overrun_d;
    logic [NUM_CH-1:0] enable_q, enable_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] ch_fire_q, ch_fire_d;
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [15:0]       readdata_q, readdata_d;

    logic              wr;
    logic              last_ch;
    logic [NUM_CH-1:0] period_wr;

`ifdef TICK_SCHED_TICK_COUNT_EN
    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic              tick_acc;
`endif

    assign wr      = bus.chipselect & ~bus.write_n;
    assign last_ch = (idx_q == IDX_W'(NUM_CH - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tick_pend_d = tick_pend_q;
        overrun_d   = overrun_q;
        enable_d    = enable_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        pending_d   = pending_q;
        ch_fire_d   = '0;
        period_d    = period_q;
        count_d     = count_q;
        period_wr   = '0;

        // Bus writes are applied first so that scan-side set/clear effects
        // below override them where the two collide.
        if (wr) begin
            case (bus.address)
                4'd0: begin
                    pending_d = pending_q & ~bus.writedata[NUM_CH-1:0];
                    if (bus.writedata[15]) begin
                        overrun_d = 1'b0;
                    end
                end
                4'd1:    enable_d = bus.writedata[NUM_CH-1:0];
                4'd2:    mask_d   = bus.writedata[NUM_CH-1:0];
                4'd3:    mode_d   = bus.writedata[NUM_CH-1:0];
                default: ;
            endcase
        end

        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (wr && (bus.address == 4'(4 + n))) begin
                period_wr[n] = 1'b1;
                period_d[n]  = bus.writedata[CNT_W-1:0];
                count_d[n]   = bus.writedata[CNT_W-1:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (tick_in) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                // A PERIOD write to the channel being scanned takes priority
                // over its decrement/fire for this tick.
                for (int unsigned n = 0; n < NUM_CH; n++) begin
                    if ((idx_q == IDX_W'(n)) && enable_q[n] && !period_wr[n]) begin
                        if (count_q[n] == CNT_W'(1)) begin
                            pending_d[n] = 1'b1;
                            ch_fire_d[n] = 1'b1;
                            count_d[n]   = period_q[n];
                            if (!mode_q[n]) begin
                                enable_d[n] = 1'b0;
                            end
                        end else if (count_q[n] != '0) begin
                            count_d[n] = count_q[n] - CNT_W'(1);
                        end
                    end
                end

                // A tick already queued means any further tick is lost. A tick
                // on the last channel with nothing queued restarts directly,
                // which is equivalent to queuing it and restarting.
                if (tick_in && tick_pend_q) begin
                    overrun_d = 1'b1;
                end

                if (last_ch) begin
                    idx_d = '0;
                    if (tick_pend_q) begin
                        tick_pend_d = 1'b0;
                    end else if (!tick_in) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (tick_in && !tick_pend_q) begin
                        tick_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef TICK_SCHED_TICK_COUNT_EN
    assign tick_acc = tick_in & ~((state_q == S_SCAN) & tick_pend_q);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (wr && (bus.address == 4'd12)) begin
            tick_cnt_d = '0;
        end
        if (tick_acc) begin
            tick_cnt_d = tick_cnt_d + 16'd1;
        end
    end
`endif

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            4'd0: begin
                readdata_d[15]         = overrun_q;
                readdata_d[NUM_CH-1:0] = pending_q;
            end
            4'd1: readdata_d[NUM_CH-1:0] = enable_q;
            4'd2: readdata_d[NUM_CH-1:0] = mask_q;
            4'd3: readdata_d[NUM_CH-1:0] = mode_q;
`ifdef TICK_SCHED_TICK_COUNT_EN
            4'd12: readdata_d = tick_cnt_q;
`endif
            default: ;
        endcase
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (bus.address == 4'(4 + n)) begin
                readdata_d[CNT_W-1:0] = period_q[n];
            end
            if (bus.address == 4'(8 + n)) begin
                readdata_d[CNT_W-1:0] = count_q[n];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tick_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            enable_q    <= '0;
            mode_q      <= '0;
            mask_q      <= '0;
            pending_q   <= '0;
            ch_fire_q   <= '0;
            readdata_q  <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                period_q[n] <= '0;
                count_q[n]  <= '0;
            end
`ifdef TICK_SCHED_TICK_COUNT_EN
            tick_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tick_pend_q <= tick_pend_d;
            overrun_q   <= overrun_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            ch_fire_q   <= ch_fire_d;
            readdata_q  <= readdata_d;
            period_q    <= period_d;
            count_q     <= count_d;
`ifdef TICK_SCHED_TICK_COUNT_EN
            tick_cnt_q  <= tick_cnt_d;
`endif
        end
    end

    assign bus.readdata = readdata_q;
    assign ch_fire      = ch_fire_q;
    assign irq          = |(pending_q & mask_q);

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler -- self-checking bench for tick_scheduler.
// The reference model applies each accepted tick to all channels at once and
// predicts the ch_fire pulse of channel k NUM_CH-staggered after the tick.
module tb_tick_scheduler;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              tick_in = 1'b0;
    logic              irq;
    logic [NUM_CH-1:0] ch_fire;

    tick_scheduler_if bus ();

    tick_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_in (tick_in),
        .bus     (bus),
        .irq     (irq),
        .ch_fire (ch_fire)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned       m_period [NUM_CH];
    int unsigned       m_count  [NUM_CH];
    bit [NUM_CH-1:0]   m_en, m_mode, m_mask, m_pend;
    bit                m_ovr;
    bit [15:0]         m_ticks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted tick applied to every channel.
    function automatic bit [NUM_CH-1:0] model_tick();
        bit [NUM_CH-1:0] f = '0;
        m_ticks++;
        for (int k = 0; k < NUM_CH; k++) begin
            if (m_en[k]) begin
                if (m_count[k] == 1) begin
                    f[k] = 1'b1;
                    m_pend[k] = 1'b1;
                    m_count[k] = m_period[k];
                    if (!m_mode[k]) m_en[k] = 1'b0;
                end else if (m_count[k] != 0) begin
                    m_count[k] = m_count[k] - 1;
                end
            end
        end
        return f;
    endfunction

    function automatic logic [15:0] model_read(input int a);
        logic [15:0] r = '0;
        if (a == 0) begin
            r[15] = m_ovr;
            r[NUM_CH-1:0] = m_pend;
        end else if (a == 1) r[NUM_CH-1:0] = m_en;
        else if (a == 2) r[NUM_CH-1:0] = m_mask;
        else if (a == 3) r[NUM_CH-1:0] = m_mode;
        else if (a >= 4 && a < 4 + NUM_CH) r = 16'(m_period[a-4]);
        else if (a >= 8 && a < 8 + NUM_CH) r = 16'(m_count[a-8]);
`ifdef TICK_SCHED_TICK_COUNT_EN
        else if (a == 12) r = m_ticks;
`endif
        return r;
    endfunction

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input int a, input logic [15:0] d);
        bus.address    = 4'(a);
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        if (a == 0) begin
            m_pend &= ~d[NUM_CH-1:0];
            if (d[15]) m_ovr = 1'b0;
        end else if (a == 1) m_en = d[NUM_CH-1:0];
        else if (a == 2) m_mask = d[NUM_CH-1:0];
        else if (a == 3) m_mode = d[NUM_CH-1:0];
        else if (a >= 4 && a < 4 + NUM_CH) begin
            m_period[a-4] = d;
            m_count[a-4]  = d;
        end else if (a == 12) m_ticks = '0;
    endtask

    task automatic bus_read(input int a, output logic [15:0] d);
        bus.address    = 4'(a);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(posedge clk); #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic read_check(input string tag, input int a);
        logic [15:0] d;
        bus_read(a, d);
        check(tag, d, model_read(a));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Single tick, then check the staggered ch_fire pattern and irq.
    task automatic tick_checked();
        bit [NUM_CH-1:0] f;
        logic [NUM_CH-1:0] e;
        f = model_tick();
        tick_in = 1'b1;
        @(posedge clk); #1;
        tick_in = 1'b0;
        for (int j = 1; j <= NUM_CH + 1; j++) begin
            @(posedge clk); #1;
            e = '0;
            if (j <= NUM_CH) e[j-1] = f[j-1];
            check("ch_fire", ch_fire, e);
        end
        check("irq", irq, |(m_pend & m_mask));
    endtask

    task automatic check_regs();
        read_check("STATUS", 0);
        read_check("ENABLE", 1);
        read_check("MASK", 2);
        read_check("MODE", 3);
        for (int k = 0; k < NUM_CH; k++) begin
            read_check("PERIOD", 4 + k);
            read_check("COUNT", 8 + k);
        end
        read_check("TICKCNT", 12);
    endtask

    initial begin
        logic [15:0] d;
        int fires;

        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        for (int k = 0; k < NUM_CH; k++) begin m_period[k] = 0; m_count[k] = 0; end
        m_en = '0; m_mode = '0; m_mask = '0; m_pend = '0; m_ovr = 1'b0; m_ticks = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", irq, 1'b0);
        check("rst_fire", ch_fire, '0);
        reset_n = 1'b1;
        idle(1);
        for (int a = 0; a < 16; a++) begin
            bus_read(a, d);
            check("rst_reg", d, 16'h0000);
        end

        // Periodic channel 0, period 3
        bus_write(4, 16'd3);
        bus_write(3, 16'h1);
        bus_write(2, 16'h1);
        bus_write(1, 16'h1);
        for (int t = 1; t <= 7; t++) begin
            tick_checked();
            if (t == 3) begin
                check("irq_tick3", irq, 1'b1);
                bus_write(0, 16'h0001);
                check("irq_after_w1c", irq, 1'b0);
            end
            if (t == 6) check("irq_tick6", irq, 1'b1);
        end
        bus_write(1, 16'h0);
        bus_write(0, 16'h000F);

        // One-shot channel 2, period 2
        bus_write(6, 16'd2);
        bus_write(3, 16'h0);
        bus_write(1, 16'h4);
        for (int t = 1; t <= 5; t++) tick_checked();
        bus_read(1, d);
        check("oneshot_enable", d, 16'h0000);
        bus_read(10, d);
        check("oneshot_count2", d, 16'd2);
        bus_write(0, 16'h000F);

        // Back-to-back ticks: two scans, one lost tick
        bus_write(4, 16'd1);
        bus_write(3, 16'h1);
        bus_write(1, 16'h1);
        fires = 0;
        tick_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            fires += int'(ch_fire[0]);
        end
        tick_in = 1'b0;
        void'(model_tick());
        void'(model_tick());
        m_ovr = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            fires += int'(ch_fire[0]);
        end
        check("burst_fires", fires, 2);
        bus_read(0, d);
        check("overrun_set", d[15], 1'b1);
        read_check("STATUS_ovr", 0);
        bus_write(0, 16'h8000);
        bus_read(0, d);
        check("overrun_clr", d[15], 1'b0);
        bus_write(1, 16'h0);
        bus_write(0, 16'h000F);

        // PERIOD write colliding with the channel's scan slot
        bus_write(5, 16'd1);
        bus_write(3, 16'h2);
        bus_write(1, 16'h2);
        tick_in = 1'b1;
        @(posedge clk); #1;
        tick_in = 1'b0;
        @(posedge clk); #1;
        bus.address = 4'd5; bus.writedata = 16'd5;
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        m_ticks++;
        m_period[1] = 5;
        m_count[1]  = 5;
        check("collide_nofire", ch_fire, '0);
        idle(3);
        bus_read(9, d);
        check("collide_count", d, 16'd5);
        for (int t = 1; t <= 5; t++) tick_checked();
        bus_write(1, 16'h0);
        bus_write(0, 16'h000F);

        // Tick counter
        bus_write(12, 16'hFFFF);
        read_check("TICKCNT_clr", 12);
        for (int t = 1; t <= 5; t++) tick_checked();
        bus_read(12, d);
`ifdef TICK_SCHED_TICK_COUNT_EN
        check("TICKCNT_5", d, 16'd5);
`else
        check("TICKCNT_off", d, 16'd0);
`endif

        // Randomized configurations
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NUM_CH; k++) bus_write(4 + k, 16'($urandom_range(0, 4)));
            bus_write(3, 16'($urandom_range(0, 15)));
            bus_write(2, 16'($urandom_range(0, 15)));
            bus_write(1, 16'($urandom_range(0, 15)));
            for (int t = 0; t < 8; t++) begin
                tick_checked();
                if ($urandom_range(0, 3) == 0) bus_write(0, 16'($urandom_range(0, 15)));
            end
            check_regs();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
